// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache controller.
package cache_pkg;

    localparam int ENTRIES  = 128;
    localparam int INDEX_W  = 7;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = 11;
    localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
    localparam int WORD_W   = 16;
    localparam int LINE_W   = 64;
    localparam int ENTRY_W  = 2 + TAG_W + LINE_W;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] line;
    } entry_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CHECK,
        EVICT,
        FILL,
        FILL_WAIT
    } state_t;

endpackage

// File: rtl/cache_word_merge.sv
// Selects one 16-bit word from a cache line and produces the line with a
// replacement word merged in at the same offset.
module cache_word_merge
    import cache_pkg::*;
(
    input  logic [LINE_W-1:0]   line,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [WORD_W-1:0]   word,
    output logic [WORD_W-1:0]   sel_word,
    output logic [LINE_W-1:0]   merged_line
);

    logic [5:0] bit_base;

    assign bit_base = {offset, 4'b0000};

    always_comb begin
        sel_word    = line[bit_base +: WORD_W];
        merged_line = line;
        merged_line[bit_base +: WORD_W] = word;
    end

endmodule

// File: rtl/cache_entry_ctrl.sv
// Direct-mapped write-back cache controller: clears the entry RAM after reset,
// serves hits, writes back dirty victims and fills lines on a miss.
//
// state     | meaning
// ----------+----------------------------------------------------------
// INIT      | sweep: write zero entry to one index per cycle
// IDLE      | accept a word request, launch entry RAM read
// CHECK     | entry RAM data present: hit service or miss dispatch
// EVICT     | write dirty victim line to backing memory
// FILL      | issue line read to backing memory
// FILL_WAIT | wait for fill data, install entry, answer reads
module cache_entry_ctrl
    import cache_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_rd,
    input  logic                     in_wr,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [WORD_W-1:0]        in_din,
    output logic                     in_wait,
    output logic                     in_valid,
    output logic [WORD_W-1:0]        in_dout,
    output logic                     out_rd,
    output logic                     out_wr,
    output logic [TAG_W+INDEX_W-1:0] out_addr,
    output logic [LINE_W-1:0]        out_din,
    input  logic                     out_waitReq,
    input  logic                     out_valid,
    input  logic [LINE_W-1:0]        out_dout,
    output logic [INDEX_W-1:0]       mem_rd_addr,
    output logic                     mem_rd_en,
    input  logic [ENTRY_W-1:0]       mem_rd_data,
    output logic [INDEX_W-1:0]       mem_wr_addr,
    output logic                     mem_wr_en,
    output logic [ENTRY_W-1:0]       mem_wr_data
);

    state_t state, state_nxt;

    logic [INDEX_W-1:0]  sweep_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [WORD_W-1:0]   req_din;
    logic                req_wr;
    logic [TAG_W-1:0]    vic_tag;
    logic [LINE_W-1:0]   vic_line;

    entry_t            rd_entry;
    logic              hit;
    logic              accept;
    logic [LINE_W-1:0] mrg_src;
    logic [LINE_W-1:0] mrg_line;
    logic [WORD_W-1:0] mrg_word;

    assign rd_entry = entry_t'(mem_rd_data);
    assign hit      = rd_entry.valid && (rd_entry.tag == req_tag);
    assign accept   = (state == IDLE) && (in_rd || in_wr);
    assign mrg_src  = (state == FILL_WAIT) ? out_dout : rd_entry.line;

    cache_word_merge u_merge (
        .line        (mrg_src),
        .offset      (req_off),
        .word        (req_din),
        .sel_word    (mrg_word),
        .merged_line (mrg_line)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                sweep_idx <= sweep_idx + INDEX_W'(1);
            end
        end
    end

    // Request and victim capture carry no reset; they are only consumed after
    // an accept / CHECK has loaded them.
    always_ff @(posedge clock) begin
        if (accept) begin
            req_tag <= in_addr[ADDR_W-1 -: TAG_W];
            req_idx <= in_addr[OFFSET_W +: INDEX_W];
            req_off <= in_addr[OFFSET_W-1:0];
            req_din <= in_din;
            req_wr  <= in_wr;
        end
        if (state == CHECK) begin
            vic_tag  <= rd_entry.tag;
            vic_line <= rd_entry.line;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_wait     = 1'b1;
        in_valid    = 1'b0;
        in_dout     = mrg_word;
        out_rd      = 1'b0;
        out_wr      = 1'b0;
        out_addr    = {req_tag, req_idx};
        out_din     = vic_line;
        mem_rd_en   = 1'b0;
        mem_rd_addr = in_addr[OFFSET_W +: INDEX_W];
        mem_wr_en   = 1'b0;
        mem_wr_addr = req_idx;
        mem_wr_data = '0;
        // Strobes are held low while reset is asserted; an abandoned backing
        // command is simply dropped.
        if (!reset) begin
            unique case (state)
                INIT: begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = sweep_idx;
                    if (sweep_idx == INDEX_W'(ENTRIES - 1)) begin
                        state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    in_wait = 1'b0;
                    if (accept) begin
                        mem_rd_en = 1'b1;
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        if (req_wr) begin
                            mem_wr_en   = 1'b1;
                            mem_wr_data = {1'b1, 1'b1, req_tag, mrg_line};
                        end else begin
                            in_valid = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else if (rd_entry.valid && rd_entry.dirty) begin
                        state_nxt = EVICT;
                    end else begin
                        state_nxt = FILL;
                    end
                end
                EVICT: begin
                    out_wr   = 1'b1;
                    out_addr = {vic_tag, req_idx};
                    if (!out_waitReq) begin
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    out_rd = 1'b1;
                    if (!out_waitReq) begin
                        state_nxt = FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (out_valid) begin
                        mem_wr_en   = 1'b1;
                        mem_wr_data = {1'b1, req_wr, req_tag,
                                       req_wr ? mrg_line : out_dout};
                        in_valid    = !req_wr;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

endmodule
